// File: rtl/rob_commit.sv
// Reorder buffer: hands out compact tags at dispatch, collects up to three
// results per cycle and retires up to three oldest completed entries in order.
module rob_commit #(
  parameter int DEPTH   = 64,
  parameter int TAG_W   = 6,
  parameter int ALLOC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_validA, alloc_validB, alloc_validC, alloc_validD,
  input  logic             alloc_wenA, alloc_wenB, alloc_wenC, alloc_wenD,
  input  logic [2:0]       alloc_dstA, alloc_dstB, alloc_dstC, alloc_dstD,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tagA, alloc_tagB, alloc_tagC, alloc_tagD,
  input  logic             cmpl_valid0, cmpl_valid1, cmpl_valid2,
  input  logic [TAG_W-1:0] cmpl_tag0, cmpl_tag1, cmpl_tag2,
  input  logic [15:0]      cmpl_data0, cmpl_data1, cmpl_data2,
  output logic             wen0, wen1, wen2,
  output logic [2:0]       waddr0, waddr1, waddr2,
  output logic [15:0]      wdata0, wdata1, wdata2,
  output logic [TAG_W-1:0] wrob0, wrob1, wrob2,
  output logic [TAG_W:0]   count
);
  localparam int NCMP = 3;
  localparam int NRET = 3;

  logic [ALLOC_W-1:0]             a_vld, a_wen, a_go;
  logic [ALLOC_W-1:0][2:0]        a_dst;
  logic [ALLOC_W-1:0][TAG_W-1:0]  a_tag;
  logic [NCMP-1:0]                c_vld, c_go;
  logic [NCMP-1:0][TAG_W-1:0]     c_tag;
  logic [NCMP-1:0][15:0]          c_data;
  logic [NRET-1:0]                r_go;
  logic [NRET-1:0][TAG_W-1:0]     r_idx;

  logic [TAG_W-1:0] head_q, tail_q;
  logic [TAG_W:0]   count_q, count_d, nalloc, ncommit;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;

  // Entry payload needs no reset: it is only read while valid/done say so.
  logic [DEPTH-1:0] ewen;
  logic [2:0]       edst  [DEPTH];
  logic [15:0]      edata [DEPTH];

  logic [NRET-1:0]             wen_q;
  logic [NRET-1:0][2:0]        waddr_q;
  logic [NRET-1:0][15:0]       wdata_q;
  logic [NRET-1:0][TAG_W-1:0]  wrob_q;

  assign a_vld  = {alloc_validD, alloc_validC, alloc_validB, alloc_validA};
  assign a_wen  = {alloc_wenD, alloc_wenC, alloc_wenB, alloc_wenA};
  assign a_dst  = {alloc_dstD, alloc_dstC, alloc_dstB, alloc_dstA};
  assign c_vld  = {cmpl_valid2, cmpl_valid1, cmpl_valid0};
  assign c_tag  = {cmpl_tag2, cmpl_tag1, cmpl_tag0};
  assign c_data = {cmpl_data2, cmpl_data1, cmpl_data0};

  // Only the registered count is used, so same-cycle retirement never helps.
  assign alloc_ready = count_q <= (TAG_W+1)'(DEPTH - ALLOC_W);

  always_comb begin
    a_tag[0] = tail_q;
    for (int j = 1; j < ALLOC_W; j++)
      a_tag[j] = a_tag[j-1] + TAG_W'(a_vld[j-1]);
    nalloc = '0;
    for (int j = 0; j < ALLOC_W; j++) begin
      a_go[j] = alloc_ready & a_vld[j];
      nalloc  = nalloc + (TAG_W+1)'(a_go[j]);
    end
  end

  assign alloc_tagA = a_tag[0];
  assign alloc_tagB = a_tag[1];
  assign alloc_tagC = a_tag[2];
  assign alloc_tagD = a_tag[3];

  // A lower-numbered port carrying the same tag shadows the higher ones.
  always_comb begin
    for (int k = 0; k < NCMP; k++) begin
      c_go[k] = c_vld[k] & valid_q[c_tag[k]] & ~done_q[c_tag[k]];
      for (int j = 0; j < k; j++)
        if (c_vld[j] && c_tag[j] == c_tag[k]) c_go[k] = 1'b0;
    end
  end

  always_comb begin
    ncommit = '0;
    for (int i = 0; i < NRET; i++) begin
      r_idx[i] = head_q + TAG_W'(i);
      r_go[i]  = ((i == 0) ? 1'b1 : r_go[i-1]) & valid_q[r_idx[i]] & done_q[r_idx[i]];
      ncommit  = ncommit + (TAG_W+1)'(r_go[i]);
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    for (int i = 0; i < NRET; i++)
      if (r_go[i]) begin
        valid_d[r_idx[i]] = 1'b0;
        done_d[r_idx[i]]  = 1'b0;
      end
    for (int k = 0; k < NCMP; k++)
      if (c_go[k]) done_d[c_tag[k]] = 1'b1;
    for (int j = 0; j < ALLOC_W; j++)
      if (a_go[j]) begin
        valid_d[a_tag[j]] = 1'b1;
        done_d[a_tag[j]]  = 1'b0;
      end
    count_d = count_q + nalloc - ncommit;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < ALLOC_W; j++)
      if (a_go[j]) begin
        ewen[a_tag[j]] <= a_wen[j];
        edst[a_tag[j]] <= a_dst[j];
      end
    for (int k = 0; k < NCMP; k++)
      if (c_go[k]) edata[c_tag[k]] <= c_data[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wrob_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
      head_q  <= flush ? '0 : head_q + ncommit[TAG_W-1:0];
      tail_q  <= flush ? '0 : tail_q + nalloc[TAG_W-1:0];
      for (int i = 0; i < NRET; i++) begin
        wen_q[i] <= ~flush & r_go[i] & ewen[r_idx[i]];
        if (r_go[i] && !flush) begin
          waddr_q[i] <= edst[r_idx[i]];
          wdata_q[i] <= edata[r_idx[i]];
          wrob_q[i]  <= r_idx[i];
        end
      end
    end
  end

  assign count  = count_q;
  assign wen0   = wen_q[0];
  assign wen1   = wen_q[1];
  assign wen2   = wen_q[2];
  assign waddr0 = waddr_q[0];
  assign waddr1 = waddr_q[1];
  assign waddr2 = waddr_q[2];
  assign wdata0 = wdata_q[0];
  assign wdata1 = wdata_q[1];
  assign wdata2 = wdata_q[2];
  assign wrob0  = wrob_q[0];
  assign wrob1  = wrob_q[1];
  assign wrob2  = wrob_q[2];

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: allocation, completion, in-order retirement,
// wrap, flush and asynchronous reset, with hand-computed expectations.
module tb_rob_commit;
  logic        clk, rst_n, flush;
  logic        alloc_validA, alloc_validB, alloc_validC, alloc_validD;
  logic        alloc_wenA, alloc_wenB, alloc_wenC, alloc_wenD;
  logic [2:0]  alloc_dstA, alloc_dstB, alloc_dstC, alloc_dstD;
  logic        alloc_ready;
  logic [5:0]  alloc_tagA, alloc_tagB, alloc_tagC, alloc_tagD;
  logic        cmpl_valid0, cmpl_valid1, cmpl_valid2;
  logic [5:0]  cmpl_tag0, cmpl_tag1, cmpl_tag2;
  logic [15:0] cmpl_data0, cmpl_data1, cmpl_data2;
  logic        wen0, wen1, wen2;
  logic [2:0]  waddr0, waddr1, waddr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [5:0]  wrob0, wrob1, wrob2;
  logic [6:0]  count;

  int tests = 0;
  int fails = 0;

  rob_commit #(.DEPTH(64), .TAG_W(6), .ALLOC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_validA(alloc_validA), .alloc_validB(alloc_validB),
    .alloc_validC(alloc_validC), .alloc_validD(alloc_validD),
    .alloc_wenA(alloc_wenA), .alloc_wenB(alloc_wenB),
    .alloc_wenC(alloc_wenC), .alloc_wenD(alloc_wenD),
    .alloc_dstA(alloc_dstA), .alloc_dstB(alloc_dstB),
    .alloc_dstC(alloc_dstC), .alloc_dstD(alloc_dstD),
    .alloc_ready(alloc_ready),
    .alloc_tagA(alloc_tagA), .alloc_tagB(alloc_tagB),
    .alloc_tagC(alloc_tagC), .alloc_tagD(alloc_tagD),
    .cmpl_valid0(cmpl_valid0), .cmpl_valid1(cmpl_valid1), .cmpl_valid2(cmpl_valid2),
    .cmpl_tag0(cmpl_tag0), .cmpl_tag1(cmpl_tag1), .cmpl_tag2(cmpl_tag2),
    .cmpl_data0(cmpl_data0), .cmpl_data1(cmpl_data1), .cmpl_data2(cmpl_data2),
    .wen0(wen0), .wen1(wen1), .wen2(wen2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .wrob0(wrob0), .wrob1(wrob1), .wrob2(wrob2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clr;
    flush = 1'b0;
    {alloc_validA, alloc_validB, alloc_validC, alloc_validD} = '0;
    {alloc_wenA, alloc_wenB, alloc_wenC, alloc_wenD} = '0;
    {alloc_dstA, alloc_dstB, alloc_dstC, alloc_dstD} = '0;
    {cmpl_valid0, cmpl_valid1, cmpl_valid2} = '0;
    {cmpl_tag0, cmpl_tag1, cmpl_tag2} = '0;
    {cmpl_data0, cmpl_data1, cmpl_data2} = '0;
  endtask

  // v/w bit 0 is slot A; destinations are d0, d0+1, d0+2, d0+3.
  task automatic set_alloc(input logic [3:0] v, input logic [3:0] w, input logic [2:0] d0);
    {alloc_validD, alloc_validC, alloc_validB, alloc_validA} = v;
    {alloc_wenD, alloc_wenC, alloc_wenB, alloc_wenA} = w;
    alloc_dstA = d0;
    alloc_dstB = d0 + 3'd1;
    alloc_dstC = d0 + 3'd2;
    alloc_dstD = d0 + 3'd3;
  endtask

  task automatic set_cmpl(input int p, input logic [5:0] t, input logic [15:0] d);
    case (p)
      0: begin cmpl_valid0 = 1'b1; cmpl_tag0 = t; cmpl_data0 = d; end
      1: begin cmpl_valid1 = 1'b1; cmpl_tag1 = t; cmpl_data1 = d; end
      default: begin cmpl_valid2 = 1'b1; cmpl_tag2 = t; cmpl_data2 = d; end
    endcase
  endtask

  task automatic do_reset;
    clr();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    tests++; if (count !== 7'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if ({wen0, wen1, wen2} !== 3'b000) begin fails++; $display("FAIL reset_wen got %b exp 000", {wen0, wen1, wen2}); end
    tests++; if ({waddr0, wdata0, wrob0} !== 25'd0) begin fails++; $display("FAIL reset_slot0 got %h exp 0", {waddr0, wdata0, wrob0}); end
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", alloc_ready); end
    tests++; if (alloc_tagA !== 6'd0) begin fails++; $display("FAIL reset_tagA got %0d exp 0", alloc_tagA); end
  endtask

  task automatic test_basic;
    do_reset();
    set_alloc(4'hF, 4'hF, 3'd1);
    #1;
    tests++; if ({alloc_tagA, alloc_tagB, alloc_tagC, alloc_tagD} !== {6'd0, 6'd1, 6'd2, 6'd3}) begin
      fails++; $display("FAIL basic_tags got %0d %0d %0d %0d exp 0 1 2 3", alloc_tagA, alloc_tagB, alloc_tagC, alloc_tagD); end
    tick(); clr();
    tests++; if (count !== 7'd4) begin fails++; $display("FAIL basic_count got %0d exp 4", count); end
    set_cmpl(0, 6'd1, 16'hAAAA);
    tick(); clr(); tick();
    tests++; if (wen0 !== 1'b0 || count !== 7'd4) begin fails++; $display("FAIL basic_no_retire got wen0=%b count=%0d exp 0 4", wen0, count); end
    set_cmpl(0, 6'd0, 16'hBBBB);
    tick(); clr();
    tests++; if (wen0 !== 1'b0) begin fails++; $display("FAIL basic_latency got wen0=%b exp 0", wen0); end
    tick();
    tests++; if ({wen0, waddr0, wdata0, wrob0} !== {1'b1, 3'd1, 16'hBBBB, 6'd0}) begin
      fails++; $display("FAIL basic_slot0 got %b %0d %h %0d exp 1 1 bbbb 0", wen0, waddr0, wdata0, wrob0); end
    tests++; if ({wen1, waddr1, wdata1, wrob1} !== {1'b1, 3'd2, 16'hAAAA, 6'd1}) begin
      fails++; $display("FAIL basic_slot1 got %b %0d %h %0d exp 1 2 aaaa 1", wen1, waddr1, wdata1, wrob1); end
    tests++; if (wen2 !== 1'b0 || count !== 7'd2) begin fails++; $display("FAIL basic_slot2 got wen2=%b count=%0d exp 0 2", wen2, count); end
  endtask

  task automatic test_compact_tags;
    do_reset();
    set_alloc(4'hF, 4'hF, 3'd0); tick();
    set_alloc(4'hF, 4'hF, 3'd0); tick();
    set_alloc(4'b0011, 4'hF, 3'd0); tick();
    set_alloc(4'b0101, 4'hF, 3'd0);
    #1;
    tests++; if ({alloc_tagA, alloc_tagB, alloc_tagC, alloc_tagD} !== {6'd10, 6'd11, 6'd11, 6'd12}) begin
      fails++; $display("FAIL compact_tags got %0d %0d %0d %0d exp 10 11 11 12", alloc_tagA, alloc_tagB, alloc_tagC, alloc_tagD); end
    tick(); clr();
    #1;
    tests++; if (count !== 7'd12 || alloc_tagA !== 6'd12) begin fails++; $display("FAIL compact_tail got count=%0d tagA=%0d exp 12 12", count, alloc_tagA); end
  endtask

  task automatic test_multi_retire;
    do_reset();
    set_alloc(4'hF, 4'hF, 3'd1); tick();
    set_alloc(4'b0001, 4'b0001, 3'd5); tick(); clr();
    set_cmpl(0, 6'd0, 16'h1000); set_cmpl(1, 6'd1, 16'h1001); set_cmpl(2, 6'd2, 16'h1002);
    tick(); clr();
    set_cmpl(0, 6'd3, 16'h1003); set_cmpl(1, 6'd4, 16'h1004);
    tick(); clr();
    tests++; if ({wen0, wen1, wen2, wrob0, wrob1, wrob2} !== {3'b111, 6'd0, 6'd1, 6'd2}) begin
      fails++; $display("FAIL multi_first got wen=%b%b%b rob %0d %0d %0d exp 111 0 1 2", wen0, wen1, wen2, wrob0, wrob1, wrob2); end
    tests++; if (waddr2 !== 3'd3 || wdata1 !== 16'h1001 || count !== 7'd2) begin
      fails++; $display("FAIL multi_first_data got waddr2=%0d wdata1=%h count=%0d exp 3 1001 2", waddr2, wdata1, count); end
    tick();
    tests++; if ({wen0, wen1, wen2, wrob0, wrob1, wrob2} !== {3'b110, 6'd3, 6'd4, 6'd2}) begin
      fails++; $display("FAIL multi_second got wen=%b%b%b rob %0d %0d %0d exp 110 3 4 2", wen0, wen1, wen2, wrob0, wrob1, wrob2); end
    tests++; if (wdata1 !== 16'h1004 || waddr1 !== 3'd5 || wdata2 !== 16'h1002 || count !== 7'd0) begin
      fails++; $display("FAIL multi_second_data got wdata1=%h waddr1=%0d wdata2=%h count=%0d exp 1004 5 1002 0", wdata1, waddr1, wdata2, count); end
    set_alloc(4'b0001, 4'b0000, 3'd6); tick(); clr();
    set_cmpl(0, 6'd5, 16'h5555); tick(); clr(); tick();
    tests++; if ({wen0, waddr0, wdata0, wrob0} !== {1'b0, 3'd6, 16'h5555, 6'd5} || count !== 7'd0) begin
      fails++; $display("FAIL multi_nowen got %b %0d %h %0d count=%0d exp 0 6 5555 5 0", wen0, waddr0, wdata0, wrob0, count); end
    tick();
    tests++; if ({wen0, wen1, wen2} !== 3'b000 || wrob0 !== 6'd5) begin
      fails++; $display("FAIL multi_empty got wen=%b%b%b wrob0=%0d exp 000 5", wen0, wen1, wen2, wrob0); end
  endtask

  task automatic test_full_wrap;
    do_reset();
    repeat (15) begin set_alloc(4'hF, 4'hF, 3'd0); tick(); end
    set_alloc(4'b0001, 4'b0001, 3'd0); tick(); clr();
    tests++; if (count !== 7'd61 || alloc_ready !== 1'b0) begin fails++; $display("FAIL full_61 got count=%0d ready=%b exp 61 0", count, alloc_ready); end
    set_alloc(4'hF, 4'hF, 3'd0); tick(); clr();
    #1;
    tests++; if (count !== 7'd61 || alloc_tagA !== 6'd61) begin fails++; $display("FAIL full_blocked got count=%0d tagA=%0d exp 61 61", count, alloc_tagA); end
    set_cmpl(0, 6'd0, 16'h0); tick(); clr(); tick();
    tests++; if (count !== 7'd60 || alloc_ready !== 1'b1) begin fails++; $display("FAIL full_60 got count=%0d ready=%b exp 60 1", count, alloc_ready); end
    set_alloc(4'b0001, 4'b0001, 3'd0); tick(); clr();
    set_cmpl(0, 6'd1, 16'h0); set_cmpl(1, 6'd2, 16'h0); set_cmpl(2, 6'd3, 16'h0);
    tick(); clr(); tick();
    tests++; if (count !== 7'd58) begin fails++; $display("FAIL full_58 got %0d exp 58", count); end
    set_alloc(4'hF, 4'hF, 3'd0);
    #1;
    tests++; if ({alloc_tagA, alloc_tagB, alloc_tagC, alloc_tagD} !== {6'd62, 6'd63, 6'd0, 6'd1}) begin
      fails++; $display("FAIL wrap_tags got %0d %0d %0d %0d exp 62 63 0 1", alloc_tagA, alloc_tagB, alloc_tagC, alloc_tagD); end
    tick(); clr();
    #1;
    tests++; if (count !== 7'd62 || alloc_tagA !== 6'd2) begin fails++; $display("FAIL wrap_tail got count=%0d tagA=%0d exp 62 2", count, alloc_tagA); end
  endtask

  task automatic test_same_tag;
    do_reset();
    set_alloc(4'hF, 4'hF, 3'd1); tick();
    set_alloc(4'b0011, 4'b0011, 3'd5); tick(); clr();
    set_cmpl(0, 6'd5, 16'h1111); set_cmpl(1, 6'd5, 16'h2222); tick(); clr();
    set_cmpl(0, 6'd5, 16'h3333); tick(); clr();
    set_cmpl(0, 6'd0, 16'h0010); set_cmpl(1, 6'd1, 16'h0011); set_cmpl(2, 6'd2, 16'h0012);
    tick(); clr();
    set_cmpl(0, 6'd3, 16'h0013); set_cmpl(1, 6'd4, 16'h0014);
    tick(); clr();
    tests++; if (wen2 !== 1'b1 || wrob2 !== 6'd2 || wdata2 !== 16'h0012) begin
      fails++; $display("FAIL same_first got wen2=%b wrob2=%0d wdata2=%h exp 1 2 0012", wen2, wrob2, wdata2); end
    tick();
    tests++; if ({wen2, waddr2, wdata2, wrob2} !== {1'b1, 3'd6, 16'h1111, 6'd5} || count !== 7'd0) begin
      fails++; $display("FAIL same_tag got %b %0d %h %0d count=%0d exp 1 6 1111 5 0", wen2, waddr2, wdata2, wrob2, count); end
  endtask

  task automatic test_flush;
    do_reset();
    set_alloc(4'hF, 4'hF, 3'd0); tick();
    set_alloc(4'hF, 4'hF, 3'd0); tick();
    set_alloc(4'b0011, 4'hF, 3'd0); tick(); clr();
    set_cmpl(0, 6'd0, 16'h0A0A); set_cmpl(1, 6'd1, 16'h0B0B); set_cmpl(2, 6'd2, 16'h0C0C);
    tick(); clr();
    flush = 1'b1;
    set_alloc(4'hF, 4'hF, 3'd0);
    tick(); clr();
    #1;
    tests++; if ({wen0, wen1, wen2} !== 3'b000 || count !== 7'd0) begin
      fails++; $display("FAIL flush_out got wen=%b%b%b count=%0d exp 000 0", wen0, wen1, wen2, count); end
    tests++; if (alloc_tagA !== 6'd0 || alloc_ready !== 1'b1 || wrob2 !== 6'd0) begin
      fails++; $display("FAIL flush_ptr got tagA=%0d ready=%b wrob2=%0d exp 0 1 0", alloc_tagA, alloc_ready, wrob2); end
    tick();
    tests++; if ({wen0, wen1, wen2} !== 3'b000 || count !== 7'd0) begin
      fails++; $display("FAIL flush_after got wen=%b%b%b count=%0d exp 000 0", wen0, wen1, wen2, count); end
  endtask

  task automatic test_reset_mid;
    set_alloc(4'hF, 4'hF, 3'd1); tick(); clr();
    set_cmpl(0, 6'd0, 16'hAAAA); set_cmpl(1, 6'd1, 16'hBBBB); tick(); clr(); tick();
    tests++; if (wen0 !== 1'b1 || wen1 !== 1'b1 || count !== 7'd2) begin
      fails++; $display("FAIL rstmid_pre got wen=%b%b count=%0d exp 11 2", wen0, wen1, count); end
    rst_n = 1'b0;
    #1;
    tests++; if ({wen0, wen1, wen2, waddr0, wdata1, wrob1} !== '0 || count !== 7'd0 || alloc_tagA !== 6'd0) begin
      fails++; $display("FAIL rstmid got wen=%b%b%b waddr0=%0d wdata1=%h wrob1=%0d count=%0d tagA=%0d exp all 0",
                        wen0, wen1, wen2, waddr0, wdata1, wrob1, count, alloc_tagA); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    test_reset();
    test_basic();
    test_compact_tags();
    test_multi_retire();
    test_full_wrap();
    test_same_tag();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
